// File: rtl/result_display_feeder.sv
// Queues writeback results in a small FIFO and presents each one on ResultD for HOLD_CYCLES clocks.
// Optional: define RESULT_X0_FILTER_EN to ignore writes whose destination register is x0.
module result_display_feeder #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    output logic [31:0] ResultD,
    output logic        shown_valid,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [HW-1:0] hold_cnt;

    logic capture, empty, full, hold_done, pop, push;

`ifdef RESULT_X0_FILTER_EN
    assign capture = RegWriteW && (RdW != 5'd0);
`else
    logic unused_rdw;
    assign unused_rdw = ^RdW;
    assign capture    = RegWriteW;
`endif

    always_comb begin
        empty     = (count == '0);
        full      = (count == FULL_CNT);
        hold_done = (hold_cnt == '0);
        pop       = !empty && ((state == IDLE) || hold_done);
        // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted
        push      = capture && (!full || pop);
    end

    assign fifo_full = full;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= ResultW;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            hold_cnt    <= '0;
            ResultD     <= '0;
            shown_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (capture && full && !pop)
                overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (pop) begin
                        ResultD     <= mem[rd_ptr];
                        shown_valid <= 1'b1;
                        hold_cnt    <= HOLD_LOAD;
                        state       <= SHOW;
                    end
                end
                SHOW: begin
                    if (!hold_done) begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end else if (pop) begin
                        ResultD  <= mem[rd_ptr];
                        hold_cnt <= HOLD_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_display_feeder.sv
// Directed bench for result_display_feeder with DEPTH=4, HOLD_CYCLES=4.
module tb_result_display_feeder;

    logic        clk;
    logic        rst;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [31:0] ResultD;
    logic        shown_valid;
    logic        fifo_full;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    result_display_feeder #(
        .DEPTH      (4),
        .HOLD_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteW  (RegWriteW),
        .RdW        (RdW),
        .ResultW    (ResultW),
        .ResultD    (ResultD),
        .shown_valid(shown_valid),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are applied at a falling edge, held across one rising edge, and outputs sampled at the next falling edge.
    task automatic cyc(input logic we, input logic [4:0] rd, input logic [31:0] res);
        RegWriteW = we;
        RdW       = rd;
        ResultW   = res;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_d;

        rst = 1'b0; RegWriteW = 1'b0; RdW = '0; ResultW = '0;
        #1;
        check("rst_resultd", ResultD, 32'h0);
        check("rst_valid", {31'b0, shown_valid}, 32'h0);
        check("rst_full", {31'b0, fifo_full}, 32'h0);
        check("rst_ovf", {31'b0, overflow}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Single capture: one edge of latency, then held through the hold and into idle
        cyc(1'b1, 5'd5, 32'hDEADBEEF);
        check("t1_latency_d", ResultD, 32'h0);
        check("t1_latency_v", {31'b0, shown_valid}, 32'h0);
        cyc(1'b0, 5'd0, 32'h0);
        check("t1_shown_d", ResultD, 32'hDEADBEEF);
        check("t1_shown_v", {31'b0, shown_valid}, 32'h1);
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 5'd0, 32'h0);
            check($sformatf("t1_held_%0d", k), ResultD, 32'hDEADBEEF);
        end
        check("t1_held_v", {31'b0, shown_valid}, 32'h1);

        // Back-to-back 1,2,3: each value visible for exactly four samples
        for (int k = 0; k < 15; k++) begin
            if (k < 3) cyc(1'b1, 5'(k + 1), 32'(k + 1));
            else       cyc(1'b0, 5'd0, 32'h0);
            exp_d = (k == 0) ? 32'hDEADBEEF : (k < 9) ? 32'(1 + (k - 1) / 4) : 32'h3;
            check($sformatf("t2_d_%0d", k), ResultD, exp_d);
        end

        // Overflow: 0x100 shown, then 0x101..0x106 pushed; 0x106 arrives full with no pop and is dropped
        for (int k = 0; k < 29; k++) begin
            if (k < 7) cyc(1'b1, 5'd3, 32'h100 + 32'(k));
            else       cyc(1'b0, 5'd0, 32'h0);
            exp_d = (k == 0) ? 32'h3 : (k < 21) ? 32'h100 + 32'((k - 1) / 4) : 32'h105;
            check($sformatf("t3_d_%0d", k), ResultD, exp_d);
            check($sformatf("t3_full_%0d", k), {31'b0, fifo_full}, (k >= 4 && k <= 8) ? 32'h1 : 32'h0);
            check($sformatf("t3_ovf_%0d", k), {31'b0, overflow}, (k >= 6) ? 32'h1 : 32'h0);
        end

        // Async reset mid-hold with two entries queued
        cyc(1'b1, 5'd1, 32'h200);
        check("t5_pre0", ResultD, 32'h105);
        cyc(1'b1, 5'd1, 32'h201);
        check("t5_pre1", ResultD, 32'h200);
        cyc(1'b1, 5'd1, 32'h202);
        check("t5_pre2", ResultD, 32'h200);
        RegWriteW = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("t5_async_d", ResultD, 32'h0);
        check("t5_async_v", {31'b0, shown_valid}, 32'h0);
        check("t5_async_ovf", {31'b0, overflow}, 32'h0);
        @(negedge clk);
        check("t5_inrst_d", ResultD, 32'h0);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 5'd0, 32'h0);
            check($sformatf("t5_post_d_%0d", k), ResultD, 32'h0);
            check($sformatf("t5_post_v_%0d", k), {31'b0, shown_valid}, 32'h0);
        end

        // Full with simultaneous pop: 0xA5 pushed on the hold-expiry edge while full
        for (int k = 0; k < 27; k++) begin
            if (k < 5)       cyc(1'b1, 5'd2, 32'h300 + 32'(k));
            else if (k == 5) cyc(1'b1, 5'd2, 32'hA5);
            else             cyc(1'b0, 5'd0, 32'h0);
            exp_d = (k == 0) ? 32'h0 : (k < 21) ? 32'h300 + 32'((k - 1) / 4) : 32'hA5;
            check($sformatf("t4_d_%0d", k), ResultD, exp_d);
            check($sformatf("t4_full_%0d", k), {31'b0, fifo_full}, (k >= 4 && k <= 8) ? 32'h1 : 32'h0);
            check($sformatf("t4_ovf_%0d", k), {31'b0, overflow}, 32'h0);
        end

        // Write to x0: captured only when the filter is not built in
        cyc(1'b1, 5'd0, 32'h77);
        check("t6_x0_edge", ResultD, 32'hA5);
        cyc(1'b0, 5'd0, 32'h0);
`ifdef RESULT_X0_FILTER_EN
        check("t6_x0_d", ResultD, 32'hA5);
`else
        check("t6_x0_d", ResultD, 32'h77);
`endif
        for (int k = 0; k < 4; k++) cyc(1'b0, 5'd0, 32'h0);
        cyc(1'b1, 5'd7, 32'h88);
        cyc(1'b0, 5'd0, 32'h0);
        check("t6_nonzero_rd", ResultD, 32'h88);
        check("t6_ovf", {31'b0, overflow}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_display_feeder.md
RESULT_DISPLAY_FEEDER -- requirements
Module: result_display_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of result FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 50_000_000, meaning the clk cycles each result is held on the display (>= 2).
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port RegWriteW, input, width 1: the writeback-stage register-write enable.
REQ-006 The block SHALL have port RdW, input, width 5: the writeback destination register index.
REQ-007 The block SHALL have port ResultW, input, width 32: the writeback result value.
REQ-008 The block SHALL have port ResultD, output, width 32: the value presented to the 7-segment display stage.
REQ-009 The block SHALL have port shown_valid, output, width 1: high once ResultD holds a captured result.
REQ-010 The block SHALL have port fifo_full, output, width 1: high when the FIFO holds DEPTH entries.
REQ-011 The block SHALL have port overflow, output, width 1: a sticky flag set when a capture is dropped.

Function
REQ-012 A capture event SHALL be a rising clk edge with RegWriteW=1, subject to REQ-026.
REQ-013 On a capture event with the FIFO not full, ResultW SHALL be written to the FIFO tail.
REQ-014 On a capture event with the FIFO full and no pop on the same edge, the data SHALL be dropped and overflow SHALL be set to 1 until reset.
REQ-015 On a capture event with the FIFO full and a pop on the same edge, the push SHALL be accepted, the occupancy SHALL stay at DEPTH, and overflow SHALL be unchanged.
REQ-016 The presenter SHALL implement a two-state FSM with states IDLE and SHOW.
REQ-017 In IDLE with the FIFO non-empty, the presenter SHALL pop the head entry into ResultD, set shown_valid=1, load hold_cnt=HOLD_CYCLES-1, and move to SHOW, all on the same edge.
REQ-018 In SHOW with hold_cnt>0, the presenter SHALL decrement hold_cnt and keep ResultD unchanged.
REQ-019 In SHOW with hold_cnt=0 and the FIFO non-empty, the presenter SHALL pop the next entry into ResultD and reload hold_cnt=HOLD_CYCLES-1.
REQ-020 In SHOW with hold_cnt=0 and the FIFO empty, the presenter SHALL move to IDLE with ResultD and shown_valid held.
REQ-021 Latency SHALL be as follows: a capture at edge N into an empty FIFO while in IDLE SHALL appear on ResultD after edge N+1.
REQ-022 Each popped value SHALL remain on ResultD for exactly HOLD_CYCLES cycles whenever a successor is queued.
REQ-023 FIFO pointers SHALL be log2(DEPTH) bits and SHALL wrap modulo DEPTH; the occupancy count SHALL be log2(DEPTH)+1 bits.
REQ-024 fifo_full SHALL be a registered flag or a pure decode of the occupancy count, and SHALL be exact on the cycle following any push or pop.
REQ-025 Entries SHALL be presented in capture order, with no reordering or duplication.

Configuration
REQ-026 Macro RESULT_X0_FILTER_EN, when defined, SHALL suppress capture events where RdW=5'd0; when undefined, every RegWriteW=1 edge SHALL be a capture event regardless of RdW.

Reset
REQ-027 On rst=0, asynchronously and without waiting for clk: ResultD=32'h0, shown_valid=0, fifo_full=0, overflow=0, FIFO empty, pointers=0, hold_cnt=0, FSM=IDLE.
REQ-028 Reset asserted mid-hold SHALL discard all queued entries; after release, no stale value SHALL appear on ResultD.
REQ-029 The first capture SHALL be sampled on the first rising clk edge after rst returns to 1.

Verification (HOLD_CYCLES=4, DEPTH=4)
REQ-030 Single capture: with RegWriteW=1, RdW=5, ResultW=32'hDEADBEEF for one cycle -> ResultD=32'hDEADBEEF one edge later, shown_valid=1, state returns to IDLE after 4 cycles with the value held.
REQ-031 Back-to-back captures: push 32'h1, 32'h2, 32'h3 on consecutive cycles -> ResultD steps 1, 2, 3 with each value held exactly 4 cycles.
REQ-032 Overflow: push 6 values in 6 consecutive cycles while the first is on display -> fifo_full=1, overflow=1, and the last dropped value never appears on ResultD.
REQ-033 Full with simultaneous pop: fill the FIFO, then push 32'hA5 on a hold-expiry edge -> overflow stays 0 and 32'hA5 is shown last.
REQ-034 x0 filter: with RESULT_X0_FILTER_EN defined, RdW=0, ResultW=32'h77 -> no change on ResultD; with the macro undefined -> ResultD=32'h77.
REQ-035 Async reset: drop rst mid-hold between clk edges with 2 entries queued -> ResultD=0 and shown_valid=0 immediately, and nothing is shown after release until a new capture.
